dm_responder: RTL and testbench
===============================

// Module: dm_responder
// PURPOSE
// - Memory-side responder for CPU data accesses (lw/sw) over a valid/ready request/response handshake.
// - Byte-organised big-endian storage with a parameterised number of wait states.
// - Replaces the zero-latency data memory once the CPU core moves to a stalling, handshaked memory port.
// - Sits between the core's load/store path (address = ALU result, write data = Rt) and the testbench.
// PARAMETERS
// - DEPTH        128  storage size in bytes; power of two, >= 4.
// - WAIT_CYCLES  2    extra cycles between request acceptance and response; 0..15.
// PORTS
// - clk        in   1   single clock; all state changes on the rising edge.
// - rst        in   1   synchronous, active-high reset.
// - req_valid  in   1   core presents a request.
// - req_ready  out  1   responder can accept a request this cycle.
// - req_write  in   1   1 = store word, 0 = load word.
// - req_addr   in   32  byte address.
// - req_wdata  in   32  store data.
// - rsp_valid  out  1   response available.
// - rsp_ready  in   1   core consumes the response.
// - rsp_rdata  out  32  load data; 0 for stores and for errors.
// - rsp_err    out  1   misaligned or out-of-range access.
// BEHAVIOUR
// - Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
// - Storage is not cleared by reset; the bench preloads it.
// - FSM states: IDLE, WAIT, RESP.
// - IDLE: req_ready=1. On req_valid&req_ready, latch write, addr and wdata.
//   - WAIT_CYCLES=0: go to RESP.
//   - Otherwise: load counter with WAIT_CYCLES-1 and go to WAIT.
//   - Request inputs are ignored in every other state.
// - WAIT: req_ready=0. Decrement the counter each cycle; at 0, go to RESP.
// - Commit edge: the edge entering RESP.
//   - Store: write mem[a]=wdata[31:24], mem[a+1]=[23:16], mem[a+2]=[15:8], mem[a+3]=[7:0].
//   - Load: rsp_rdata={mem[a],mem[a+1],mem[a+2],mem[a+3]}.
// - Latency: rsp_valid first high WAIT_CYCLES+1 cycles after the acceptance edge.
// - RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_valid&rsp_ready.
//   - On that handshake: go to IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0.
//   - No back-to-back acceptance: at most one request is outstanding; the next is accepted no earlier than the cycle after the response handshake.
// - Errors: rsp_err=1 if addr[1:0]!=0, or if addr > DEPTH-4 (unsigned, full 32 bits).
//   - An erroring store does not modify storage; an erroring load returns rsp_rdata=0.
//   - Timing is identical to a good access.
// - Address arithmetic: index = addr[$clog2(DEPTH)-1:0], used only after the range check passes, so there is no wrap-around.
// - Reset mid-operation: rst in WAIT or RESP returns to IDLE.
//   - A store not yet committed is discarded; a store already committed is kept.
//   - Any pending response is dropped.
// - rst has priority over every handshake in the same cycle.
// STRUCTURE
// - Shared package: FSM state encoding (IDLE=2'd0, WAIT=2'd1, RESP=2'd2) and WORD_BYTES=4, both reused by the core's memory-stall logic.
// - One sub-module: dm_byte_array (combinational big-endian word read, synchronous write on a write-enable).
// - The FSM, counter and error check stay in dm_responder.
// TESTING
// 1. Preload mem[0..3]=11,22,33,44 (hex); WAIT_CYCLES=2; load addr 0 with rsp_ready=1 -> rsp_valid rises 3 cycles after acceptance with rsp_rdata=0x11223344, rsp_err=0.
// 2. Store 0xDEADBEEF to addr 8, then load addr 8 -> load returns 0xDEADBEEF; mem[8]=0xDE, mem[11]=0xEF.
// 3. Load addr 6, then store to addr DEPTH -> both give rsp_err=1 and rsp_rdata=0; storage unchanged.
// 4. Hold rsp_ready=0 for 5 cycles after a load -> rsp_valid and rsp_rdata held stable and req_ready=0 throughout; response completes on the first cycle rsp_ready=1.
// 5. Store accepted with WAIT_CYCLES=3, rst asserted in WAIT -> returns to IDLE, target word unchanged, req_ready=1 on the cycle after reset.
// 6. WAIT_CYCLES=0 with req_valid held high continuously -> one response per 2 cycles minimum; req_ready low in RESP.

Source files
------------

// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder and the core's memory-stall logic.
package dm_responder_pkg;

    // Responder FSM encoding, also decoded by the core's stall logic
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    localparam int unsigned WORD_BYTES = 4;

    // One captured request
    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dm_req_t;

    // Misaligned, or the last byte of the word would fall past the end of storage
    function automatic logic addr_bad(input logic [31:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || (addr > 32'(depth - WORD_BYTES));
    endfunction

endpackage

// File: rtl/dm_byte_array.sv
// Byte-organised storage: combinational big-endian word read, synchronous word write.
module dm_byte_array
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [7:0] mem [DEPTH];

    // Word write, most significant byte at the lowest address
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(WORD_BYTES); b++) begin
                mem[idx + AW'(b)] <= wdata[31 - 8 * b -: 8];
            end
        end
    end

    // Word read, most significant byte from the lowest address
    always_comb begin
        rdata = '0;
        for (int b = 0; b < int'(WORD_BYTES); b++) begin
            rdata[31 - 8 * b -: 8] = mem[idx + AW'(b)];
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Memory-side responder for CPU lw/sw over a valid/ready request/response handshake,
// with a fixed number of wait states between acceptance and response.
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int unsigned DEPTH       = 128,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dm_req_t     req_q, req_d, cur;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        commit, cur_bad, mem_we;
    logic [31:0] mem_rdata;

    // With zero wait states the commit edge is the acceptance edge, so the live request is used
    always_comb begin
        cur = req_q;
        if (state_q == StIdle) begin
            cur.write = req_write;
            cur.addr  = req_addr;
            cur.wdata = req_wdata;
        end
        cur_bad = addr_bad(cur.addr, DEPTH);
        commit  = ((state_q == StIdle) && req_valid && (WAIT_CYCLES == 0)) ||
                  ((state_q == StWait) && (cnt_q == 4'd0));
        mem_we  = commit && cur.write && !cur_bad && !rst;
    end

    dm_byte_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (cur.addr[AW-1:0]),
        .wdata (cur.wdata),
        .rdata (mem_rdata)
    );

    // FSM, wait counter and response registers next-state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    req_d = cur;
                    if (WAIT_CYCLES == 0) begin
                        state_d = StResp;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (commit) begin
            err_d   = cur_bad;
            rdata_d = (!cur.write && !cur_bad) ? mem_rdata : 32'h0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: three instances with 2, 3 and 0 wait states.
module tb_dm_responder;

    localparam int unsigned DEPTH = 128;
    localparam int NI = 3;

    function automatic int unsigned wc_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 3 : 0);
    endfunction

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst       [NI];
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_write [NI];
    logic [31:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic        rsp_valid [NI];
    logic        rsp_ready [NI];
    logic [31:0] rsp_rdata [NI];
    logic        rsp_err   [NI];

    exp_t exp_q [NI][$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter for latency and spacing measurements
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s: event did not occur", name);
    endtask

    for (genvar g = 0; g < NI; g++) begin : gen_dut
        dm_responder #(
            .DEPTH       (DEPTH),
            .WAIT_CYCLES (wc_of(g))
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g])
        );

        int          acc_cyc    = 0;
        int          last_hs    = -1;
        logic        prev_valid = 1'b0;
        logic        prev_stall = 1'b0;
        logic [31:0] held_rdata = '0;
        logic        held_err   = 1'b0;

        // Monitor: pops the scoreboard on each response handshake
        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                if (rst[g]) begin
                    prev_valid = 1'b0;
                    prev_stall = 1'b0;
                    last_hs    = -1;
                    continue;
                end
                if (req_valid[g] && req_ready[g]) acc_cyc = cyc;
                if (rsp_valid[g]) begin
                    check($sformatf("req_ready_in_resp[%0d]", g), 32'(req_ready[g]), 32'd0);
                    if (!prev_valid) begin
                        check($sformatf("latency[%0d]", g), 32'(cyc - acc_cyc), wc_of(g) + 1);
                    end
                    if (prev_stall) begin
                        check($sformatf("stall_rdata[%0d]", g), rsp_rdata[g], held_rdata);
                        check($sformatf("stall_err[%0d]", g), 32'(rsp_err[g]), 32'(held_err));
                    end
                    if (rsp_ready[g]) begin
                        if (last_hs >= 0) begin
                            check($sformatf("rsp_spacing_ge2[%0d]", g),
                                  32'((cyc - last_hs) >= 2), 32'd1);
                        end
                        last_hs = cyc;
                        if (exp_q[g].size() == 0) begin
                            fail($sformatf("expected_entry_for_rsp[%0d]", g));
                        end else begin
                            e = exp_q[g].pop_front();
                            check($sformatf("rsp_rdata[%0d]", g), rsp_rdata[g], e.rdata);
                            check($sformatf("rsp_err[%0d]", g), 32'(rsp_err[g]), 32'(e.err));
                        end
                    end
                end
                prev_valid = rsp_valid[g];
                prev_stall = rsp_valid[g] && !rsp_ready[g];
                held_rdata = rsp_rdata[g];
                held_err   = rsp_err[g];
            end
        end
    end

    // One complete transaction; hold = cycles rsp_ready stays low once rsp_valid is seen
    task automatic do_req(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input logic exp_err, input int hold);
        exp_t e;
        int   t;
        rsp_ready[i] = (hold == 0);
        @(posedge clk); #1;
        t = 0;
        while (!req_ready[i] && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready[i]) begin
            fail("req_ready_timeout");
            return;
        end
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i]  = a;
        req_wdata[i] = d;
        e.rdata = exp_rd;
        e.err   = exp_err;
        exp_q[i].push_back(e);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        t = 0;
        while (!rsp_valid[i] && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (!rsp_valid[i]) begin
            fail("rsp_valid_timeout");
            return;
        end
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            rsp_ready[i] = 1'b1;
        end
        @(posedge clk); #1;
        check("rsp_valid_after_handshake", 32'(rsp_valid[i]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            rst[i]       = 1'b1;
            req_valid[i] = 1'b0;
            req_write[i] = 1'b0;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            rsp_ready[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) rst[i] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("reset_req_ready", 32'(req_ready[i]), 32'd1);
            check("reset_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            check("reset_rsp_rdata", rsp_rdata[i], 32'd0);
            check("reset_rsp_err", 32'(rsp_err[i]), 32'd0);
        end

        // Preload, then basic load with latency check
        do_req(0, 1'b1, 32'd0, 32'h1122_3344, 32'h0, 1'b0, 0);
        do_req(0, 1'b0, 32'd0, 32'h0, 32'h1122_3344, 1'b0, 0);
        // Store then load back, byte order in storage
        do_req(0, 1'b1, 32'd8, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        do_req(0, 1'b0, 32'd8, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        check("mem8", 32'(gen_dut[0].u_dut.u_array.mem[8]), 32'hDE);
        check("mem11", 32'(gen_dut[0].u_dut.u_array.mem[11]), 32'hEF);
        // Errors: misaligned load, out-of-range store, misaligned store, huge address
        do_req(0, 1'b0, 32'd6, 32'h0, 32'h0, 1'b1, 0);
        do_req(0, 1'b1, DEPTH, 32'h1234_5678, 32'h0, 1'b1, 0);
        do_req(0, 1'b1, 32'd6, 32'h5555_5555, 32'h0, 1'b1, 0);
        do_req(0, 1'b0, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 0);
        // Last legal word
        do_req(0, 1'b1, DEPTH - 4, 32'hCAFE_F00D, 32'h0, 1'b0, 0);
        do_req(0, 1'b0, DEPTH - 4, 32'h0, 32'hCAFE_F00D, 1'b0, 0);
        // Erroring stores left storage intact; last one also stalls rsp_ready for 5 cycles
        do_req(0, 1'b0, 32'd0, 32'h0, 32'h1122_3344, 1'b0, 0);
        do_req(0, 1'b0, 32'd8, 32'h0, 32'hDEAD_BEEF, 1'b0, 5);

        // Reset while a store waits: the store must be discarded
        do_req(1, 1'b1, 32'd16, 32'hA5A5_A5A5, 32'h0, 1'b0, 0);
        @(posedge clk); #1;
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 32'd16;
        req_wdata[1] = 32'h0;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        rst[1]       = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        check("after_rst_req_ready", 32'(req_ready[1]), 32'd1);
        check("after_rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("after_rst_no_rsp", 32'(rsp_valid[1]), 32'd0);
        check("after_rst_word", {gen_dut[1].u_dut.u_array.mem[16], gen_dut[1].u_dut.u_array.mem[17],
                                 gen_dut[1].u_dut.u_array.mem[18], gen_dut[1].u_dut.u_array.mem[19]},
              32'hA5A5_A5A5);
        do_req(1, 1'b0, 32'd16, 32'h0, 32'hA5A5_A5A5, 1'b0, 0);

        // Zero wait states, req_valid held for 12 edges: exactly 6 loads accepted
        do_req(2, 1'b1, 32'd0, 32'h0BAD_CAFE, 32'h0, 1'b0, 0);
        for (int k = 0; k < 6; k++) begin
            e.rdata = 32'h0BAD_CAFE;
            e.err   = 1'b0;
            exp_q[2].push_back(e);
        end
        rsp_ready[2] = 1'b1;
        @(posedge clk); #1;
        req_valid[2] = 1'b1;
        req_write[2] = 1'b0;
        req_addr[2]  = 32'd0;
        repeat (12) @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("burst_responses_left", 32'(exp_q[2].size()), 32'd0);
        check("burst_idle_ready", 32'(req_ready[2]), 32'd1);

        for (int i = 0; i < NI; i++) check("queue_drained", 32'(exp_q[i].size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
